// File: rtl/wb_seq_reader_if.sv
// -----------------------------------------------------------------------------
// wb_seq_reader_if
// Bundles every non-clock signal of the sequential Wishbone reader.
//   Control : start, base_adr, len (to reader) / busy, done (from reader)
//   Wishbone: cyc, stb, we, adr, sel, dat_ms (from reader) / dat_sm, ack (to it)
//   Stream  : dout_data, dout_valid (from reader) / dout_ready (to reader)
// Modport master is the reader's view, slave is the memory/consumer view.
// -----------------------------------------------------------------------------
interface wb_seq_reader_if #(
    parameter int ADR_W = 11
);
    logic             start;
    logic [ADR_W-1:0] base_adr;
    logic [ADR_W:0]   len;
    logic             busy;
    logic             done;
    logic             cyc;
    logic             stb;
    logic             we;
    logic [31:0]      adr;
    logic [3:0]       sel;
    logic [31:0]      dat_ms;
    logic [31:0]      dat_sm;
    logic             ack;
    logic [31:0]      dout_data;
    logic             dout_valid;
    logic             dout_ready;

    modport master (
        input  start, base_adr, len, dat_sm, ack, dout_ready,
        output busy, done, cyc, stb, we, adr, sel, dat_ms, dout_data, dout_valid
    );

    modport slave (
        output start, base_adr, len, dat_sm, ack, dout_ready,
        input  busy, done, cyc, stb, we, adr, sel, dat_ms, dout_data, dout_valid
    );
endinterface

// File: rtl/wb_seq_reader.sv
// -----------------------------------------------------------------------------
// wb_seq_reader
// Reads len consecutive 32-bit words starting at base_adr over Wishbone and
// streams them out through a first-word-fall-through FIFO.
//   clk : single rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : wb_seq_reader_if.master (control, Wishbone master, output stream)
// One bus request at a time; every ack is followed by a fixed two-cycle gap
// that swallows the slave's trailing ack pipeline. A request is only issued
// while the FIFO has room, so a push can never hit a full FIFO.
// -----------------------------------------------------------------------------
module wb_seq_reader #(
    parameter int ADR_W      = 11,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_seq_reader_if.master       bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             gap_q, gap_d;
    logic [ADR_W-1:0] addr_q, addr_d;
    logic [ADR_W:0]   rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             stb_q, stb_d;

    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [CNT_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] fifo_cnt_s;
    logic             room_s;
    logic             push_s;
    logic             pop_s;

    // Pointers carry one extra wrap bit, so their difference spans 0..FIFO_DEPTH.
    assign fifo_cnt_s = wr_ptr_q - rd_ptr_q;
    assign room_s     = (fifo_cnt_s < CNT_W'(FIFO_DEPTH));
    assign push_s     = (state_q == ST_REQ) && stb_q && bus.ack;
    assign pop_s      = (fifo_cnt_s != {CNT_W{1'b0}}) && bus.dout_ready;

    // FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gap_q   <= 1'b0;
            addr_q  <= {ADR_W{1'b0}};
            rem_q   <= {(ADR_W+1){1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            stb_q   <= stb_d;
        end
    end

    // Next-state logic for the request sequencer.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.len == {(ADR_W+1){1'b0}}) begin
                        // Empty transfer completes without touching the bus.
                        done_d = 1'b1;
                    end else begin
                        addr_d  = bus.base_adr;
                        rem_d   = bus.len;
                        busy_d  = 1'b1;
                        state_d = room_s ? ST_REQ : ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (push_s) begin
                    // Address wraps silently at 2^ADR_W.
                    addr_d  = addr_q + ADR_W'(1);
                    rem_d   = rem_q - (ADR_W+1)'(1);
                    gap_d   = 1'b0;
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_GAP: begin
                if (!gap_q) begin
                    gap_d = 1'b1;
                end else if (rem_q == {(ADR_W+1){1'b0}}) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = room_s ? ST_REQ : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (room_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
        // Strobe is registered: it follows the state the FSM is entering.
        stb_d = (state_d == ST_REQ);
    end

    // FIFO read/write pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= {CNT_W{1'b0}};
            rd_ptr_q <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + CNT_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + CNT_W'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= bus.dat_sm;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.cyc        = stb_q;
    assign bus.stb        = stb_q;
    assign bus.we         = 1'b0;
    assign bus.adr        = {{(32-ADR_W){1'b0}}, addr_q};
    assign bus.sel        = 4'b1111;
    assign bus.dat_ms     = 32'h0000_0000;
    assign bus.dout_data  = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign bus.dout_valid = (fifo_cnt_s != {CNT_W{1'b0}});

endmodule

// File: tb/tb_wb_seq_reader.sv
module tb_wb_seq_reader;
    localparam int ADR_W = 11;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_seq_reader_if #(.ADR_W(ADR_W)) bus ();

    wb_seq_reader #(.ADR_W(ADR_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] mem_word(input logic [ADR_W-1:0] a);
        return 32'h0000_0100 + 32'(a);
    endfunction

    // Memory slave: ack two cycles after seeing a strobe, one-cycle ack.
    int scnt = 0;
    always @(posedge clk) begin
        bus.ack <= 1'b0;
        if (scnt == 0) begin
            if (bus.cyc && bus.stb && !bus.ack) scnt <= 1;
        end else if (scnt == 1) begin
            scnt       <= 2;
            bus.ack    <= 1'b1;
            bus.dat_sm <= mem_word(bus.adr[ADR_W-1:0]);
        end else begin
            scnt <= 0;
        end
    end

    // Monitor: logs acked addresses, popped data, strobe cycles, occupancy.
    logic [31:0] rx_q[$];
    logic [31:0] adr_log[$];
    int acks = 0, stb_cycles = 0, cyc_cycles = 0, occ = 0, max_occ = 0, viol = 0;
    always @(posedge clk) begin
        if (!rst) begin
            occ = 0;
        end else begin
            if (bus.stb && occ >= DEPTH) viol++;
            if (bus.stb) stb_cycles++;
            if (bus.cyc) cyc_cycles++;
            if (bus.stb && bus.ack) begin
                adr_log.push_back(bus.adr);
                acks++;
                occ++;
            end
            if (bus.dout_valid && bus.dout_ready) begin
                rx_q.push_back(bus.dout_data);
                occ--;
            end
            if (occ > max_occ) max_occ = occ;
        end
    end

    int rx0, ad0, st0, cy0, ac0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Caller is at a negedge; pulses start for exactly one rising edge.
    task automatic kick(input logic [ADR_W-1:0] b, input logic [ADR_W:0] l,
                        input bit rdy, output bit busy1);
        rx0 = rx_q.size(); ad0 = adr_log.size();
        st0 = stb_cycles;  cy0 = cyc_cycles; ac0 = acks;
        bus.base_adr   = b;
        bus.len        = l;
        bus.start      = 1'b1;
        bus.dout_ready = rdy;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        busy1     = bus.busy;
    endtask

    task automatic wait_done(input int lat0, input int maxc, output int lat);
        lat = lat0;
        while (!bus.done && lat < maxc) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        chk("done_seen", bus.done, 1'b1);
        chk("busy_at_done", bus.busy, 1'b0);
        @(posedge clk); @(negedge clk);
        chk("done_one_cycle", bus.done, 1'b0);
    endtask

    task automatic drain();
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 40 && bus.dout_valid; i++) begin
            @(posedge clk); @(negedge clk);
        end
        chk("drained", bus.dout_valid, 1'b0);
    endtask

    task automatic verify_stream(input logic [ADR_W-1:0] b, input int l);
        logic [ADR_W-1:0] a;
        chk("word_count", rx_q.size() - rx0, l);
        chk("ack_count", adr_log.size() - ad0, l);
        for (int k = 0; k < l; k++) begin
            a = b + ADR_W'(k);
            if (rx0 + k < rx_q.size())     chk("stream_data", rx_q[rx0 + k], mem_word(a));
            if (ad0 + k < adr_log.size()) chk("bus_adr", adr_log[ad0 + k], 32'(a));
        end
    endtask

    typedef struct {
        logic [ADR_W-1:0] base;
        logic [ADR_W:0]   len;
        bit               rdy;
        int               exp_lat;
        int               exp_stb;
    } vec_t;

    initial begin
        vec_t vecs[6];
        bit   b1;
        int   lat;

        // Each word costs 3 strobe cycles + 2 gap cycles; done one edge later.
        vecs[0] = '{11'd0,    12'd4, 1'b1, 21, 12};
        vecs[1] = '{11'd2046, 12'd4, 1'b1, 21, 12};
        vecs[2] = '{11'd16,   12'd0, 1'b1, 1,  0};
        vecs[3] = '{11'd5,    12'd1, 1'b1, 6,  3};
        vecs[4] = '{11'd100,  12'd8, 1'b0, 41, 24};
        vecs[5] = '{11'd2047, 12'd2, 1'b1, 11, 6};

        bus.start = 1'b0; bus.base_adr = '0; bus.len = '0; bus.dout_ready = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_cyc", bus.cyc, 1'b0);
        chk("rst_stb", bus.stb, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_valid", bus.dout_valid, 1'b0);
        chk("rst_adr", bus.adr, 32'h0);
        chk("rst_we", bus.we, 1'b0);
        chk("rst_sel", bus.sel, 4'hF);
        chk("rst_dat_ms", bus.dat_ms, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Table vectors; the first start coincides with reset release.
        for (int i = 0; i < 6; i++) begin
            kick(vecs[i].base, vecs[i].len, vecs[i].rdy, b1);
            chk("busy_after_start", b1, vecs[i].len != 0);
            wait_done(1, 500, lat);
            chk("done_latency", lat, vecs[i].exp_lat);
            drain();
            verify_stream(vecs[i].base, int'(vecs[i].len));
            chk("stb_cycles", stb_cycles - st0, vecs[i].exp_stb);
            chk("cyc_cycles", cyc_cycles - cy0, vecs[i].exp_stb);
        end

        // Start while busy is ignored.
        kick(11'd0, 12'd3, 1'b1, b1);
        repeat (4) begin @(posedge clk); @(negedge clk); end
        bus.base_adr = 11'd500; bus.len = 12'd7; bus.start = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        wait_done(6, 500, lat);
        chk("busy_start_latency", lat, 16);
        repeat (15) begin @(posedge clk); @(negedge clk); end
        verify_stream(11'd0, 3);
        chk("busy_start_idle", bus.busy, 1'b0);

        // Full FIFO stalls the sequencer in WAIT until the consumer drains.
        kick(11'd20, 12'd12, 1'b0, b1);
        repeat (80) begin @(posedge clk); @(negedge clk); end
        chk("stall_acks", acks - ac0, 8);
        chk("stall_stb", bus.stb, 1'b0);
        chk("stall_stb_cycles", stb_cycles - st0, 24);
        chk("stall_busy", bus.busy, 1'b1);
        chk("stall_head", bus.dout_data, mem_word(11'd20));
        bus.dout_ready = 1'b1;
        wait_done(1, 600, lat);
        drain();
        verify_stream(11'd20, 12);

        // Asynchronous reset during the third request.
        kick(11'd0, 12'd8, 1'b0, b1);
        lat = 0;
        while (!((acks - ac0) == 2 && bus.stb) && lat < 100) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        chk("reached_req3", ((acks - ac0) == 2) && bus.stb, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("arst_cyc", bus.cyc, 1'b0);
        chk("arst_stb", bus.stb, 1'b0);
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_valid", bus.dout_valid, 1'b0);
        chk("arst_adr", bus.adr, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) begin @(posedge clk); @(negedge clk); end
        chk("post_arst_valid", bus.dout_valid, 1'b0);
        chk("post_arst_busy", bus.busy, 1'b0);
        kick(11'd300, 12'd3, 1'b1, b1);
        wait_done(1, 500, lat);
        chk("post_arst_latency", lat, 16);
        drain();
        verify_stream(11'd300, 3);

        // Random back-pressure over a long transfer.
        kick(11'd1000, 12'd64, 1'b0, b1);
        lat = 1;
        while (!bus.done && lat < 3000) begin
            bus.dout_ready = 1'($urandom_range(0, 1));
            @(posedge clk); lat++; @(negedge clk);
        end
        chk("rand_done_seen", bus.done, 1'b1);
        drain();
        verify_stream(11'd1000, 64);
        chk("max_occ_le_depth", max_occ <= DEPTH, 1'b1);
        chk("no_req_when_full", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
